// File: rtl/riscv_pkg.sv
// Shared hazard-control types: PC-stall encodings, FSM states and the
// load-use detection rule.
package riscv_pkg;

    localparam logic [1:0] PC_RUN  = 2'b00;
    localparam logic [1:0] PC_HOLD = 2'b01;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0] pc_stall;
        logic       pc_sel;
        logic       if_id_stall;
        logic       if_id_flush;
        logic       id_ex_stall;
        logic       id_ex_flush;
        logic       ex_mem_stall;
    } hz_ctl_t;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic       rs1_used,
        input logic [4:0] rs2,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller side.
interface hazard_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [4:0]            id_rs1_i;
    logic [4:0]            id_rs2_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic [4:0]            ex_rd_i;
    logic                  ex_mem_read_i;
    logic                  ex_branch_taken_i;
    logic [DATA_WIDTH-1:0] ex_target_i;
    logic                  dmem_busy_i;
    logic [1:0]            pc_stall_o;
    logic                  pc_sel_o;
    logic [DATA_WIDTH-1:0] pc_imm_o;
    logic                  if_id_stall_o;
    logic                  if_id_flush_o;
    logic                  id_ex_stall_o;
    logic                  id_ex_flush_o;
    logic                  ex_mem_stall_o;
    logic                  err_o;
    logic [CNT_WIDTH-1:0]  stall_cnt_o;
    logic [CNT_WIDTH-1:0]  flush_cnt_o;

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_target_i, dmem_busy_i,
        output pc_stall_o, pc_sel_o, pc_imm_o, if_id_stall_o, if_id_flush_o,
               id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, err_o,
               stall_cnt_o, flush_cnt_o
    );

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, ex_target_i, dmem_busy_i,
        input  pc_stall_o, pc_sel_o, pc_imm_o, if_id_stall_o, if_id_flush_o,
               id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, err_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at MAX; clear wins over increment.
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch redirect, load-use bubble,
// perf counters and a sticky data-memory timeout flag.
//   state       | meaning
//   ST_RUN      | normal issue; redirect / load-use handled combinationally
//   ST_MEM_WAIT | data memory busy; pipeline frozen until busy drops
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);
    localparam int BUSY_W = $clog2(TIMEOUT + 1);

    state_e                state_q, state_d;
    hz_ctl_t               ctl;
    logic                  err_q, err_d;
    logic [BUSY_W-1:0]     busy_cnt;
    logic [CNT_WIDTH-1:0]  stall_cnt, flush_cnt;

    always_comb begin
        state_d      = state_q;
        ctl          = '0;
        ctl.pc_stall = PC_RUN;
        if (!rst_i) begin
            case (state_q)
                ST_RUN:      if (bus.dmem_busy_i)  state_d = ST_MEM_WAIT;
                ST_MEM_WAIT: if (!bus.dmem_busy_i) state_d = ST_RUN;
                default:                           state_d = ST_RUN;
            endcase

            // The MEM_WAIT exit cycle is not frozen, so a held redirect fires there once.
            if (bus.dmem_busy_i) begin
                ctl.pc_stall     = PC_HOLD;
                ctl.if_id_stall  = 1'b1;
                ctl.id_ex_stall  = 1'b1;
                ctl.ex_mem_stall = 1'b1;
            end else if (bus.ex_branch_taken_i) begin
                ctl.pc_sel      = 1'b1;
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end else if (load_use_hazard(bus.id_rs1_i, bus.id_rs1_used_i,
                                         bus.id_rs2_i, bus.id_rs2_used_i,
                                         bus.ex_rd_i, bus.ex_mem_read_i)) begin
                ctl.pc_stall    = PC_HOLD;
                ctl.if_id_stall = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end
        end
    end

    // Flag on the edge where the busy run reaches TIMEOUT.
    assign err_d = err_q || (bus.dmem_busy_i && (busy_cnt >= BUSY_W'(TIMEOUT - 1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ctl.pc_stall == PC_HOLD),
        .clear_i (1'b0),
        .cnt_o   (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ctl.pc_sel),
        .clear_i (1'b0),
        .cnt_o   (flush_cnt)
    );

    sat_counter #(.WIDTH(BUSY_W), .MAX(BUSY_W'(TIMEOUT))) u_busy_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (bus.dmem_busy_i),
        .clear_i (!bus.dmem_busy_i),
        .cnt_o   (busy_cnt)
    );

    assign bus.pc_stall_o     = ctl.pc_stall;
    assign bus.pc_sel_o       = ctl.pc_sel;
    assign bus.pc_imm_o       = bus.ex_target_i;
    assign bus.if_id_stall_o  = ctl.if_id_stall;
    assign bus.if_id_flush_o  = ctl.if_id_flush;
    assign bus.id_ex_stall_o  = ctl.id_ex_stall;
    assign bus.id_ex_flush_o  = ctl.id_ex_flush;
    assign bus.ex_mem_stall_o = ctl.ex_mem_stall;
    assign bus.err_o          = err_q;
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int TOUT    = 4;
    localparam int CMAX    = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0] pc_stall;
        logic       pc_sel;
        logic       if_id_stall;
        logic       if_id_flush;
        logic       id_ex_stall;
        logic       id_ex_flush;
        logic       ex_mem_stall;
    } ctl_t;

    typedef struct packed {
        logic          rst;
        logic [4:0]    rs1;
        logic          u1;
        logic [4:0]    rs2;
        logic          u2;
        logic [4:0]    rd;
        logic          mr;
        logic          br;
        logic [DW-1:0] tgt;
        logic          busy;
    } in_t;

    typedef struct packed {
        in_t  in;
        ctl_t exp;
    } vec_t;

    localparam ctl_t C_RUN    = 8'b00_0_0_0_0_0_0;
    localparam ctl_t C_FREEZE = 8'b01_0_1_0_1_0_1;
    localparam ctl_t C_REDIR  = 8'b00_1_0_1_0_1_0;
    localparam ctl_t C_LU     = 8'b01_0_1_0_0_1_0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    hazard_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TOUT), .CNT_WIDTH(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_stall = 0, m_flush = 0, m_busy = 0;
    bit m_err = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic in_t mk(input logic r, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic [DW-1:0] tgt,
                               input logic busy);
        in_t v;
        v.rst = r; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.mr = mr; v.br = br; v.tgt = tgt; v.busy = busy;
        return v;
    endfunction

    // Behavioural response, straight from the priority rules.
    function automatic ctl_t model(input in_t v);
        bit dep;
        if (v.rst)  return C_RUN;
        if (v.busy) return C_FREEZE;
        if (v.br)   return C_REDIR;
        dep = v.mr && (v.rd != 0) &&
              ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        return dep ? C_LU : C_RUN;
    endfunction

    function automatic ctl_t read_ctl();
        ctl_t c;
        c.pc_stall     = bus.pc_stall_o;
        c.pc_sel       = bus.pc_sel_o;
        c.if_id_stall  = bus.if_id_stall_o;
        c.if_id_flush  = bus.if_id_flush_o;
        c.id_ex_stall  = bus.id_ex_stall_o;
        c.id_ex_flush  = bus.id_ex_flush_o;
        c.ex_mem_stall = bus.ex_mem_stall_o;
        return c;
    endfunction

    task automatic cycle(input in_t v, input ctl_t exp, input string tag);
        ctl_t m;
        @(negedge clk);
        rst                   = v.rst;
        bus.id_rs1_i          = v.rs1;
        bus.id_rs1_used_i     = v.u1;
        bus.id_rs2_i          = v.rs2;
        bus.id_rs2_used_i     = v.u2;
        bus.ex_rd_i           = v.rd;
        bus.ex_mem_read_i     = v.mr;
        bus.ex_branch_taken_i = v.br;
        bus.ex_target_i       = v.tgt;
        bus.dmem_busy_i       = v.busy;
        #1;
        chk({tag, ".ctl"}, 64'(read_ctl()), 64'(exp));
        if (exp.pc_sel) chk({tag, ".pc_imm"}, 64'(bus.pc_imm_o), 64'(v.tgt));
        m = model(v);
        if (v.rst) begin
            m_stall = 0; m_flush = 0; m_busy = 0; m_err = 0;
        end else begin
            if (m.pc_stall == 2'b01 && m_stall < CMAX) m_stall++;
            if (m.pc_sel && m_flush < CMAX) m_flush++;
            m_busy = v.busy ? ((m_busy < TOUT) ? m_busy + 1 : TOUT) : 0;
            if (m_busy == TOUT) m_err = 1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt_o), 64'(m_stall));
        chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt_o), 64'(m_flush));
        chk({tag, ".err"},       64'(bus.err_o),       64'(m_err));
    endtask

    task automatic run(input in_t v, input string tag);
        cycle(v, model(v), tag);
    endtask

    task automatic do_reset();
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
    endtask

    in_t idle, lu5, brn, bsy;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        lu5  = mk(0, 5, 1, 0, 0, 5, 1, 0, 32'h0, 0);
        brn  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0);
        bsy  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);

        bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0;
        bus.ex_rd_i = 0; bus.ex_mem_read_i = 0; bus.ex_branch_taken_i = 0;
        bus.ex_target_i = 0; bus.dmem_busy_i = 0;

        do_reset();
        chk("rst.stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
        chk("rst.err",       64'(bus.err_o),       64'd0);

        tbl.push_back('{in: mk(0, 1, 1, 2, 1, 3, 0, 0, 32'h10, 0),  exp: C_RUN});
        tbl.push_back('{in: mk(0, 5, 1, 0, 0, 5, 1, 0, 32'h0, 0),   exp: C_LU});
        tbl.push_back('{in: mk(0, 3, 1, 7, 1, 7, 1, 0, 32'h0, 0),   exp: C_LU});
        tbl.push_back('{in: mk(0, 0, 1, 0, 1, 0, 1, 0, 32'h0, 0),   exp: C_RUN});
        tbl.push_back('{in: mk(0, 5, 0, 1, 1, 5, 1, 0, 32'h0, 0),   exp: C_RUN});
        tbl.push_back('{in: mk(0, 5, 1, 5, 1, 5, 0, 0, 32'h0, 0),   exp: C_RUN});
        tbl.push_back('{in: mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0),  exp: C_REDIR});
        tbl.push_back('{in: mk(0, 5, 1, 0, 0, 5, 1, 1, 32'h80, 0),  exp: C_REDIR});
        tbl.push_back('{in: mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 1),  exp: C_FREEZE});
        tbl.push_back('{in: mk(0, 5, 1, 0, 0, 5, 1, 0, 32'h0, 1),   exp: C_FREEZE});
        tbl.push_back('{in: mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0, 0),  exp: C_REDIR});
        tbl.push_back('{in: mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h44, 1),  exp: C_RUN});
        tbl.push_back('{in: mk(1, 5, 1, 0, 0, 5, 1, 1, 32'h44, 0),  exp: C_RUN});
        foreach (tbl[i]) cycle(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

        // single load-use bubble, then resume
        do_reset();
        cycle(lu5, C_LU, "lu");
        cycle(idle, C_RUN, "lu.after");
        chk("lu.stall_cnt", 64'(bus.stall_cnt_o), 64'd1);

        // taken branch
        do_reset();
        cycle(brn, C_REDIR, "br");
        chk("br.flush_cnt", 64'(bus.flush_cnt_o), 64'd1);

        // branch held through three busy cycles: redirect exactly once at exit
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1), C_FREEZE, "brbusy.frz");
        cycle(brn, C_REDIR, "brbusy.exit");
        cycle(idle, C_RUN, "brbusy.after");
        chk("brbusy.flush_cnt", 64'(bus.flush_cnt_o), 64'd1);
        chk("brbusy.stall_cnt", 64'(bus.stall_cnt_o), 64'd3);
        chk("brbusy.err",       64'(bus.err_o),       64'd0);

        // dmem timeout: sticky until reset
        do_reset();
        for (int i = 0; i < 3; i++) cycle(bsy, C_FREEZE, "tout.busy");
        chk("tout.err_early", 64'(bus.err_o), 64'd0);
        cycle(bsy, C_FREEZE, "tout.busy4");
        chk("tout.err_set", 64'(bus.err_o), 64'd1);
        cycle(idle, C_RUN, "tout.idle");
        cycle(idle, C_RUN, "tout.idle");
        chk("tout.err_hold", 64'(bus.err_o), 64'd1);
        do_reset();
        chk("tout.err_clr", 64'(bus.err_o), 64'd0);

        // reset in the middle of MEM_WAIT
        cycle(bsy, C_FREEZE, "rstmw.busy");
        cycle(bsy, C_FREEZE, "rstmw.busy");
        cycle(mk(1, 5, 1, 0, 0, 5, 1, 1, 32'h40, 1), C_RUN, "rstmw.rst");
        chk("rstmw.stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
        chk("rstmw.flush_cnt", 64'(bus.flush_cnt_o), 64'd0);
        cycle(lu5, C_LU, "rstmw.release");

        // counter saturation
        do_reset();
        for (int i = 0; i < CMAX + 3; i++) run(lu5, "sat.stall");
        chk("sat.stall_cnt", 64'(bus.stall_cnt_o), 64'(CMAX));
        for (int i = 0; i < CMAX + 3; i++) run(brn, "sat.flush");
        chk("sat.flush_cnt", 64'(bus.flush_cnt_o), 64'(CMAX));

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_t v;
            v.rst  = ($urandom_range(0, 99) < 3);
            v.rs1  = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom_range(0, 1));
            v.rs2  = 5'($urandom_range(0, 3));
            v.u2   = 1'($urandom_range(0, 1));
            v.rd   = 5'($urandom_range(0, 3));
            v.mr   = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 99) < 20);
            v.tgt  = $urandom;
            v.busy = ($urandom_range(0, 99) < 35);
            run(v, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
